mdio_multiport_target: RTL and testbench

Clause-22 MDIO management-frame target serving NUM_PORTS consecutive PHY addresses, clocked from MDC. Checks the preamble and ST field, then decodes OP, PHYAD and REGAD. Matched writes are delivered to the register bank. Matched reads fetch RD_DATA and shift it back to the station with a correct turnaround. It sits between the MDIO station/pad logic and the per-port management register banks, and supersedes the single-port receiver.

---
 rtl/mdio_pkg.sv | 22 ++
 rtl/mdio_tx_shift.sv | 41 ++++
 rtl/mdio_multiport_target.sv | 177 +++++++++++++++++
 tb/tb_mdio_multiport_target.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, header layout and FSM states for the Clause-22 MDIO target.
package mdio_pkg;

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] ST_PATTERN = 2'b01;
  localparam logic [1:0] TA_WRITE   = 2'b10;
  localparam int         TA_BITS    = 2;
  localparam int         DATA_BITS  = 16;
  localparam int         HDR_BITS   = 12;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] phyad;
    logic [4:0] regad;
  } mdio_hdr_t;

  typedef enum logic [2:0] {
    S_PRE, S_HDR, S_TA_W, S_WDATA, S_TA_R, S_RDATA, S_SKIP
  } mdio_state_e;

endpackage

// File: rtl/mdio_tx_shift.sv
// Parallel-load MSB-first shifter that drives the read turnaround and data bits.
module mdio_tx_shift
  import mdio_pkg::*;
(
  input  logic                 mdc_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [DATA_BITS-1:0] load_data_i,
  input  logic                 shift_i,
  input  logic                 release_i,
  output logic                 sdo_o,
  output logic                 oe_o
);

  logic [DATA_BITS-1:0] data_q;
  logic                 sdo_q;
  logic                 oe_q;

  always_ff @(posedge mdc_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
      sdo_q  <= 1'b0;
      oe_q   <= 1'b0;
    end else if (load_i) begin
      // Load drives the second turnaround bit as 0 while the word waits.
      data_q <= load_data_i;
      sdo_q  <= 1'b0;
      oe_q   <= 1'b1;
    end else if (shift_i) begin
      data_q <= {data_q[DATA_BITS-2:0], 1'b0};
      sdo_q  <= data_q[DATA_BITS-1];
    end else if (release_i) begin
      sdo_q <= 1'b0;
      oe_q  <= 1'b0;
    end
  end

  assign sdo_o = sdo_q;
  assign oe_o  = oe_q;

endmodule

// File: rtl/mdio_multiport_target.sv
// Clause-22 MDIO target answering NUM_PORTS consecutive PHY addresses from BASE_PHYAD.
module mdio_multiport_target
  import mdio_pkg::*;
#(
  parameter  int         NUM_PORTS  = 4,
  parameter  logic [4:0] BASE_PHYAD = 5'd0,
  parameter  int         PRE_LEN    = 32,
  localparam int         PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic          MDC,
  input  logic          reset,
  input  logic          MDIO_OUT,
  input  logic          MDIO_OE,
  input  logic [15:0]   RD_DATA,
  output logic          MDIO_IN,
  output logic          MDIO_IN_OE,
  output logic [PW-1:0] PORT_SEL,
  output logic [4:0]    ADDR,
  output logic [15:0]   WR_DATA,
  output logic          WR_STB,
  output logic          RD_STB,
  output logic          MDIO_DONE,
  output logic          FRAME_ERR
);

  localparam int         CW     = $clog2(PRE_LEN + 2);
  localparam logic [5:0] PHY_LO = {1'b0, BASE_PHYAD};
  localparam logic [5:0] PHY_HI = PHY_LO + 6'(NUM_PORTS);

  mdio_state_e           state_q;
  logic [CW-1:0]         pre_cnt_q;
  logic                  st_armed_q;
  logic [4:0]            bit_cnt_q;
  logic [HDR_BITS-2:0]   hdr_q;
  logic [DATA_BITS-2:0]  wsh_q;
  logic [PW-1:0]         port_sel_q;
  logic [4:0]            addr_q;
  logic [DATA_BITS-1:0]  wr_data_q;
  logic                  wr_stb_q, rd_stb_q, done_q, err_q;

  mdio_hdr_t             hdr_d;
  logic [DATA_BITS-1:0]  wdata_d;
  logic                  phy_match;
  logic                  tx_load, tx_shift, tx_release;

  assign hdr_d     = {hdr_q, MDIO_OUT};
  assign wdata_d   = {wsh_q, MDIO_OUT};
  assign phy_match = ({1'b0, hdr_d.phyad} >= PHY_LO) && ({1'b0, hdr_d.phyad} < PHY_HI);

  always_ff @(posedge MDC or posedge reset) begin
    if (reset) begin
      state_q    <= S_PRE;
      pre_cnt_q  <= '0;
      st_armed_q <= 1'b0;
      bit_cnt_q  <= '0;
      hdr_q      <= '0;
      wsh_q      <= '0;
      port_sel_q <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: every pulse defaults low here, so only the branch that fires it sets it.
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_PRE: if (MDIO_OE) begin
          if (st_armed_q) begin
            st_armed_q <= 1'b0;
            pre_cnt_q  <= '0;
            if (MDIO_OUT == ST_PATTERN[0]) begin
              state_q   <= S_HDR;
              bit_cnt_q <= '0;
            end
          end else if (MDIO_OUT != ST_PATTERN[1]) begin
            if (pre_cnt_q < CW'(PRE_LEN)) pre_cnt_q <= pre_cnt_q + CW'(1);
          end else if (pre_cnt_q >= CW'(PRE_LEN)) begin
            st_armed_q <= 1'b1;
          end else begin
            pre_cnt_q <= '0;
          end
        end
        S_HDR, S_TA_W, S_WDATA: if (!MDIO_OE) begin
          // Station dropped its drive mid-frame: abandon the frame.
          err_q     <= 1'b1;
          state_q   <= S_PRE;
          pre_cnt_q <= '0;
        end else if (state_q == S_HDR) begin
          hdr_q     <= hdr_d[HDR_BITS-2:0];
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(HDR_BITS - 1)) begin
            bit_cnt_q <= '0;
            if (hdr_d.op != OP_WRITE && hdr_d.op != OP_READ) begin
              err_q   <= 1'b1;
              state_q <= S_PRE;
            end else if (!phy_match) begin
              state_q <= S_SKIP;
            end else begin
              addr_q     <= hdr_d.regad;
              port_sel_q <= PW'(hdr_d.phyad - BASE_PHYAD);
              if (hdr_d.op == OP_WRITE) begin
                state_q <= S_TA_W;
              end else begin
                state_q  <= S_TA_R;
                rd_stb_q <= 1'b1;
              end
            end
          end
        end else if (state_q == S_TA_W) begin
          if (MDIO_OUT != TA_WRITE[~bit_cnt_q[0]]) begin
            err_q   <= 1'b1;
            state_q <= S_PRE;
          end else if (bit_cnt_q == 5'(TA_BITS - 1)) begin
            state_q   <= S_WDATA;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end else begin
          wsh_q     <= wdata_d[DATA_BITS-2:0];
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(DATA_BITS - 1)) begin
            wr_data_q <= wdata_d;
            wr_stb_q  <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_PRE;
          end
        end
        S_TA_R: begin
          state_q   <= S_RDATA;
          bit_cnt_q <= '0;
        end
        S_RDATA: if (bit_cnt_q == 5'(DATA_BITS)) begin
          done_q  <= 1'b1;
          state_q <= S_PRE;
        end else begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
        S_SKIP: if (bit_cnt_q == 5'(TA_BITS + DATA_BITS - 1)) begin
          state_q <= S_PRE;
        end else begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
        default: state_q <= S_PRE;
      endcase
    end
  end

  assign tx_load    = (state_q == S_TA_R);
  assign tx_shift   = (state_q == S_RDATA) && (bit_cnt_q != 5'(DATA_BITS));
  assign tx_release = (state_q == S_RDATA) && (bit_cnt_q == 5'(DATA_BITS));

  mdio_tx_shift u_tx (
    .mdc_i       (MDC),
    .reset_i     (reset),
    .load_i      (tx_load),
    .load_data_i (RD_DATA),
    .shift_i     (tx_shift),
    .release_i   (tx_release),
    .sdo_o       (MDIO_IN),
    .oe_o        (MDIO_IN_OE)
  );

  assign PORT_SEL  = port_sel_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;
  assign WR_STB    = wr_stb_q;
  assign RD_STB    = rd_stb_q;
  assign MDIO_DONE = done_q;
  assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_mdio_multiport_target.sv
// Scoreboard bench: frame-level reference model feeds an expected-event queue drained by a monitor.
module tb_mdio_multiport_target;

  localparam int         NP   = 4;
  localparam logic [4:0] BASE = 5'd8;
  localparam int         PL   = 32;

  logic        MDC = 1'b0;
  logic        reset = 1'b0;
  logic        MDIO_OUT = 1'b1;
  logic        mdio_oe = 1'b0;
  logic        use0 = 1'b0;
  logic [15:0] RD_DATA = '0;
  logic        oe_main, oe_zero;

  assign oe_main = mdio_oe & ~use0;
  assign oe_zero = mdio_oe & use0;

  logic m_in, m_oe, m_wr, m_rd, m_done, m_err;
  logic [1:0] m_port; logic [4:0] m_addr; logic [15:0] m_wdata;
  logic z_in, z_oe, z_wr, z_rd, z_done, z_err;
  logic [1:0] z_port; logic [4:0] z_addr; logic [15:0] z_wdata;

  mdio_multiport_target #(.NUM_PORTS(NP), .BASE_PHYAD(BASE), .PRE_LEN(PL)) dut (
    .MDC(MDC), .reset(reset), .MDIO_OUT(MDIO_OUT), .MDIO_OE(oe_main), .RD_DATA(RD_DATA),
    .MDIO_IN(m_in), .MDIO_IN_OE(m_oe), .PORT_SEL(m_port), .ADDR(m_addr), .WR_DATA(m_wdata),
    .WR_STB(m_wr), .RD_STB(m_rd), .MDIO_DONE(m_done), .FRAME_ERR(m_err));

  mdio_multiport_target #(.NUM_PORTS(NP), .BASE_PHYAD(BASE), .PRE_LEN(0)) dut_nopre (
    .MDC(MDC), .reset(reset), .MDIO_OUT(MDIO_OUT), .MDIO_OE(oe_zero), .RD_DATA(RD_DATA),
    .MDIO_IN(z_in), .MDIO_IN_OE(z_oe), .PORT_SEL(z_port), .ADDR(z_addr), .WR_DATA(z_wdata),
    .WR_STB(z_wr), .RD_STB(z_rd), .MDIO_DONE(z_done), .FRAME_ERR(z_err));

  always #5 MDC = ~MDC;

  int cyc = 0;
  always @(posedge MDC) cyc <= cyc + 1;

  typedef enum {EV_WR, EV_RDREQ, EV_RDDONE, EV_ERR} ev_kind_e;
  typedef struct {
    int          dut;
    ev_kind_e    kind;
    int          cyc;
    int          port;
    int          addr;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  int          oe_cnt[2];
  int          oe_first[2];
  logic [16:0] ser[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: outcome of one frame derived from its fields and the edge e of the last REGAD bit.
  task automatic expect_frame(input int id, input int pl, input int pre, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] reg_a, input logic [1:0] ta,
                              input logic [15:0] data, input int abort, input int e);
    ev_t ev;
    ev.dut = id; ev.port = 0; ev.addr = int'(reg_a); ev.data = data; ev.kind = EV_ERR; ev.cyc = e;
    if (pre < pl) return;
    if (op == 2'b00 || op == 2'b11) begin exp_q.push_back(ev); return; end
    if (int'(phy) < int'(BASE) || int'(phy) >= int'(BASE) + NP) return;
    ev.port = int'(phy) - int'(BASE);
    if (op == 2'b01) begin
      if (ta[1] !== 1'b1)       ev.cyc = e + 1;
      else if (ta[0] !== 1'b0)  ev.cyc = e + 2;
      else if (abort >= 0)      ev.cyc = e + 3 + abort;
      else begin ev.kind = EV_WR; ev.cyc = e + 18; end
      exp_q.push_back(ev);
    end else begin
      ev.kind = EV_RDREQ; ev.cyc = e;      exp_q.push_back(ev);
      ev.kind = EV_RDDONE; ev.cyc = e + 18; exp_q.push_back(ev);
    end
  endtask

  task automatic observe(input int id, input logic wr, input logic rd, input logic done,
                         input logic err, input logic [1:0] port, input logic [4:0] addr,
                         input logic [15:0] wdata, input logic oe, input logic sdo);
    ev_t ev;
    if (oe) begin
      if (oe_cnt[id] == 0) oe_first[id] = cyc;
      ser[id] = {ser[id][15:0], sdo};
      oe_cnt[id]++;
    end
    if (wr | rd | done | err) begin
      check("strobe_overlap", {rd & wr, rd & done, rd & err, err & done, err & wr}, 5'b0);
      if (exp_q.size() == 0 || exp_q[0].dut != id) begin
        check($sformatf("unexpected_event_dut%0d", id), {wr, rd, done, err}, 4'b0);
      end else begin
        ev = exp_q.pop_front();
        check("event_cycle", cyc, ev.cyc);
        case (ev.kind)
          EV_WR: begin
            check("wr_flags", {wr, rd, done, err}, 4'b1010);
            check("wr_port", port, ev.port);
            check("wr_addr", addr, ev.addr);
            check("wr_data", wdata, ev.data);
          end
          EV_RDREQ: begin
            check("rd_req_flags", {wr, rd, done, err}, 4'b0100);
            check("rd_port", port, ev.port);
            check("rd_addr", addr, ev.addr);
          end
          EV_RDDONE: begin
            check("rd_done_flags", {wr, rd, done, err}, 4'b0010);
            check("rd_released", oe, 1'b0);
            check("rd_drive_len", oe_cnt[id], 17);
            check("rd_drive_start", oe_first[id], ev.cyc - 17);
            check("rd_serial", ser[id], {1'b0, ev.data});
            oe_cnt[id] = 0;
          end
          default: check("err_flags", {wr, rd, done, err}, 4'b0001);
        endcase
      end
    end
  endtask

  always @(negedge MDC) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin oe_cnt[k] = 0; oe_first[k] = 0; ser[k] = '0; end
    end else begin
      observe(0, m_wr, m_rd, m_done, m_err, m_port, m_addr, m_wdata, m_oe, m_in);
      observe(1, z_wr, z_rd, z_done, z_err, z_port, z_addr, z_wdata, z_oe, z_in);
    end
  end

  task automatic drive(input logic b, input logic oe);
    @(negedge MDC);
    MDIO_OUT = b;
    mdio_oe  = oe;
  endtask

  task automatic send_frame(input int id, input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] reg_a, input logic [1:0] ta, input logic [15:0] data,
                            input int abort, input int rst_at, input bit guard, input int idle);
    logic [11:0] hdr;
    int e;
    use0 = (id == 1);
    hdr  = {op, phy, reg_a};
    if (guard) drive(1'b0, 1'b1);
    repeat (pre) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    for (int i = 11; i >= 0; i--) drive(hdr[i], 1'b1);
    e = cyc + 1;
    expect_frame(id, (id == 1) ? 0 : PL, pre, op, phy, reg_a, ta, data, abort, e);
    if (op == 2'b10) begin
      for (int i = 0; i < 18; i++) begin
        drive(1'($urandom), 1'($urandom));
        RD_DATA = (i == 0) ? data : 16'($urandom);
        if (i == rst_at) begin
          #2;
          check("oe_before_reset", m_oe, 1'b1);
          reset = 1'b1;
          #1;
          check("outputs_in_reset", {m_in, m_oe, m_port, m_addr, m_wdata, m_wr, m_rd, m_done, m_err}, 0);
          exp_q.delete();
          repeat (2) @(posedge MDC);
          #2 reset = 1'b0;
          return;
        end
      end
    end else begin
      drive(ta[1], 1'b1);
      drive(ta[0], 1'b1);
      for (int i = 0; i < 16; i++) drive(data[15-i], i != abort);
    end
    repeat (idle) drive(1'b1, 1'b0);
  endtask

  initial begin
    logic [1:0] op;
    logic [1:0] ta;
    int r;
    #1 reset = 1'b1;
    repeat (3) @(negedge MDC);
    check("reset_outputs", {m_in, m_oe, m_port, m_addr, m_wdata, m_wr, m_rd, m_done, m_err}, 0);
    check("reset_outputs_nopre", {z_in, z_oe, z_port, z_addr, z_wdata, z_wr, z_rd, z_done, z_err}, 0);
    @(posedge MDC);
    #2 reset = 1'b0;

    // Directed frames: write, read, out-of-range skip, short preamble, protocol errors.
    send_frame(0, 32, 2'b01, 5'd10, 5'd3,  2'b10, 16'hA5C3, -1, -1, 1, 2);
    send_frame(0, 32, 2'b10, 5'd9,  5'd31, 2'b10, 16'h1234, -1, -1, 1, 1);
    send_frame(0, 32, 2'b01, 5'd20, 5'd4,  2'b10, 16'hFFFF, -1, -1, 1, 0);
    send_frame(0, 32, 2'b01, 5'd11, 5'd17, 2'b10, 16'h0F0F, -1, -1, 0, 1);
    send_frame(0, 32, 2'b01, 5'd12, 5'd1,  2'b10, 16'h5555, -1, -1, 1, 1);
    send_frame(0, 32, 2'b10, 5'd8,  5'd0,  2'b10, 16'h8001, -1, -1, 1, 1);
    send_frame(0, 20, 2'b01, 5'd8,  5'd5,  2'b10, 16'hDEAD, -1, -1, 1, 1);
    send_frame(0, 32, 2'b10, 5'd7,  5'd2,  2'b10, 16'hC0DE, -1, -1, 1, 1);
    send_frame(0, 32, 2'b10, 5'd11, 5'd9,  2'b10, 16'h7E81, -1, -1, 1, 1);
    send_frame(0, 32, 2'b01, 5'd10, 5'd6,  2'b11, 16'h1111, -1, -1, 1, 1);
    send_frame(0, 32, 2'b01, 5'd10, 5'd6,  2'b00, 16'h2222, -1, -1, 1, 1);
    send_frame(0, 32, 2'b01, 5'd10, 5'd6,  2'b10, 16'h3333,  5, -1, 1, 1);
    send_frame(0, 32, 2'b11, 5'd10, 5'd6,  2'b10, 16'h4444, -1, -1, 1, 1);
    send_frame(0, 32, 2'b00, 5'd30, 5'd6,  2'b10, 16'h4444, -1, -1, 1, 1);
    send_frame(0, 32, 2'b01, 5'd9,  5'd12, 2'b10, 16'hBEEF, -1, -1, 1, 0);

    // Randomized frames around the served address window.
    for (int n = 0; n < 30; n++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      ta = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b10;
      send_frame(0, int'($urandom_range(32, 36)), op, 5'($urandom_range(6, 13)), 5'($urandom), ta,
                 16'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1,
                 -1, 1, int'($urandom_range(0, 3)));
    end

    // Preamble suppression: ST straight after idle.
    send_frame(1, 0, 2'b01, 5'd11, 5'd21, 2'b10, 16'h6B2D, -1, -1, 0, 1);
    send_frame(1, 0, 2'b10, 5'd8,  5'd30, 2'b10, 16'h9C47, -1, -1, 0, 1);

    // Reset during read data bit 8, then a complete frame.
    send_frame(0, 32, 2'b10, 5'd10, 5'd7,  2'b10, 16'hFACE, -1, 10, 1, 0);
    send_frame(0, 32, 2'b01, 5'd8,  5'd14, 2'b10, 16'h0BAD, -1, -1, 1, 1);
    send_frame(0, 32, 2'b10, 5'd11, 5'd15, 2'b10, 16'hA0A5, -1, -1, 1, 1);

    repeat (30) drive(1'b1, 1'b0);
    check("exp_queue_drained", exp_q.size(), 0);
    check("no_stray_drive", oe_cnt[0], 0);
    check("no_stray_drive_nopre", oe_cnt[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
